// File: rtl/regfile_pkg.sv
// Shared types and constants for the quad-core register file arbiter.
// Mode encodings follow the register file's own mode pin definition.
package regfile_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 64;
    localparam int AW_DEF   = 5;

    localparam logic [1:0] MODE_WRITE = 2'b11;
    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_IDLE  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the
// rotating pointer; the pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= IW'((int'(idx) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register file among NREQ cores, sequencing its level-sensitive
// mode/st/in pins so that every access is framed by a real change on mode.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int DW   = DW_DEF,
    parameter  int AW   = AW_DEF,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic [1:0]         rf_mode,
    output logic [AW-1:0]      rf_st,
    output logic [DW-1:0]      rf_in,
    input  logic [DW-1:0]      rf_out
);

    state_t        state;
    state_t        state_nx;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0] arb_idx;
    logic [IW-1:0] owner;
    logic          op_we;
    logic          take;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .en    (state == S_IDLE && !rst),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign take = |arb_grant;
    assign gnt  = arb_grant;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (take) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // rf_st/rf_in only move on the IDLE->SETUP edge, while mode is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= '0;
            op_we   <= 1'b0;
            rf_mode <= MODE_IDLE;
            rf_st   <= '0;
            rf_in   <= '0;
            rdata   <= '0;
            done    <= '0;
        end else begin
            done <= '0;
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        owner <= arb_idx;
                        op_we <= we[arb_idx];
                        rf_st <= addr[arb_idx*AW +: AW];
                        if (we[arb_idx]) begin
                            rf_in <= wdata[arb_idx*DW +: DW];
                        end
                    end
                end
                S_SETUP: begin
                    rf_mode <= op_we ? MODE_WRITE : MODE_READ;
                end
                S_ACCESS: begin
                    rf_mode     <= MODE_IDLE;
                    done[owner] <= 1'b1;
                    if (!op_we) begin
                        rdata <= rf_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural register file
// and a transaction-level reference model (grant order, latency, data).
module tb_regfile_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int AW   = 5;

    typedef struct {
        int          owner;
        bit          w;
        logic [63:0] data;
        int          due;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   we = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [1:0]        rf_mode;
    logic [AW-1:0]     rf_st;
    logic [DW-1:0]     rf_in;
    logic [DW-1:0]     rf_out;

    logic [DW-1:0] rf_mem [32];
    logic [DW-1:0] mmem [32];

    int          cyc = 0;
    logic        rst_q;
    int          checks = 0;
    int          fails = 0;
    bit          gflag [NREQ];
    sb_t         sb [$];
    int          ptr = 0;
    int          gcyc = -100;
    logic [4:0]  cur_a = '0;
    bit          cur_w = 1'b0;
    logic [63:0] cur_d = '0;
    logic [63:0] m_rdata = '0;

    regfile_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .done    (done),
        .rdata   (rdata),
        .busy    (busy),
        .rf_mode (rf_mode),
        .rf_st   (rf_st),
        .rf_in   (rf_in),
        .rf_out  (rf_out)
    );

    always #5 clk = ~clk;

    // Register file: writes while mode is write, drives out while mode is read
    always @(posedge clk) begin
        if (rf_mode == 2'b11) rf_mem[rf_st] <= rf_in;
    end
    assign rf_out = (rf_mode == 2'b00) ? rf_mem[rf_st] : '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor and reference model
    initial begin
        logic [NREQ-1:0] eg;
        int off;
        int j;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                sb.delete();
                ptr     = 0;
                gcyc    = -100;
                m_rdata = '0;
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_mode", 64'(rf_mode), 64'(MODE_IDLE));
                chk("rst_st", 64'(rf_st), 64'(0));
                chk("rst_in", rf_in, 64'(0));
                chk("rst_rdata", rdata, 64'(0));
            end else begin
                off = cyc - gcyc;
                chk("busy", 64'(busy), 64'(off >= 1 && off <= 3));
                chk("rf_mode", 64'(rf_mode),
                    (off == 2) ? (cur_w ? 64'd3 : 64'd0) : 64'd1);
                if (off >= 1 && off <= 3) begin
                    chk("rf_st", 64'(rf_st), 64'(cur_a));
                    if (cur_w) chk("rf_in", rf_in, cur_d);
                end
                eg = '0;
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    eg = NREQ'(1) << sb[0].owner;
                    if (!sb[0].w) m_rdata = sb[0].data;
                    void'(sb.pop_front());
                end
                chk("done", 64'(done), 64'(eg));
                chk("rdata", rdata, m_rdata);
            end
            eg = '0;
            j  = 0;
            if (!rst && (cyc - gcyc) >= 4) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req[(ptr + k) % NREQ]) j = (ptr + k) % NREQ;
                end
                if (req != 0) eg = NREQ'(1) << j;
            end
            chk("gnt", 64'(gnt), 64'(eg));
            if (eg != 0) begin
                gflag[j] = 1'b1;
                cur_a = addr[j*AW +: AW];
                cur_w = we[j];
                cur_d = wdata[j*DW +: DW];
                gcyc  = cyc;
                ptr   = (j + 1) % NREQ;
                if (cur_w) begin
                    mmem[cur_a] = cur_d;
                    sb.push_back('{j, 1'b1, 64'h0, cyc + 3});
                end else begin
                    sb.push_back('{j, 1'b0, mmem[cur_a], cyc + 3});
                end
            end
        end
    end

    task automatic do_req(input int i, input bit w, input logic [4:0] a,
                          input logic [63:0] d);
        int n;
        n = 0;
        we[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
        while (!gflag[i] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!gflag[i]) begin
            checks++;
            fails++;
            $display("FAIL grant_timeout core %0d at cycle %0d", i, cyc);
        end
        gflag[i] = 1'b0;
        req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while ((busy || sb.size() != 0 || req != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout at cycle %0d", cyc);
        end
    endtask

    task automatic rand_core(input int i);
        repeat (12) begin
            repeat ($urandom_range(0, 5)) begin
                @(posedge clk);
                #1;
            end
            do_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   {$urandom, $urandom});
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            rf_mem[k] = '0;
            mmem[k]   = '0;
        end
        for (int k = 0; k < NREQ; k++) gflag[k] = 1'b0;

        req  = 4'b1111;
        we   = 4'b0001;
        addr = {5'd3, 5'd2, 5'd1, 5'd9};
        wdata = {4{64'h0123_4567_89AB_CDEF}};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        req = '0;
        wait_idle();
        for (int k = 0; k < NREQ; k++) gflag[k] = 1'b0;

        do_req(2, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
        do_req(0, 1'b0, 5'd5, 64'h0);
        wait_idle();

        fork
            do_req(1, 1'b1, 5'd31, 64'd1);
            begin
                @(posedge clk);
                #1;
                do_req(3, 1'b1, 5'd31, 64'd2);
            end
        join
        do_req(0, 1'b0, 5'd31, 64'h0);
        wait_idle();

        do_req(1, 1'b1, 5'd7, 64'hAA);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(3, 1'b0, 5'd7, 64'h0);
        wait_idle();

        do_req(2, 1'b1, 5'd0, 64'h5555_AAAA_1234_0000);
        do_req(1, 1'b0, 5'd0, 64'h0);
        wait_idle();

        for (int c = 0; c < NREQ; c++) begin
            automatic int cc = c;
            fork
                rand_core(cc);
            join_none
        end
        wait fork;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
